// File: rtl/reg_wb_ctrl.sv
// reg_wb_ctrl: register-file writeback arbiter. Pipeline writes always win; multi-cycle
// results wait in a FIFO and drain into writeback slots the pipeline leaves free.
module reg_wb_ctrl #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_a3,
    input  logic [31:0] pipe_wd,
    input  logic [31:0] pipe_pc,
    input  logic        md_valid,
    input  logic [4:0]  md_a3,
    input  logic [31:0] md_wd,
    input  logic [31:0] md_pc,
    output logic        md_ready,
    input  logic [4:0]  q_a,
    output logic        q_pending,
    output logic        RegWrite,
    output logic [4:0]  a3,
    output logic [31:0] WD,
    output logic [31:0] pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [4:0]       r_fa3 [DEPTH];
    logic [31:0]      r_fwd [DEPTH];
    logic [31:0]      r_fpc [DEPTH];
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_pipe_issue;
    logic             w_pop;
    logic             w_push;
    logic [DEPTH-1:0] w_hit;
    assign md_ready     = r_count < CW'(DEPTH);
    assign w_pipe_issue = pipe_valid && (pipe_a3 != 5'd0);
    assign w_pop        = !w_pipe_issue && (r_count != '0);
    assign w_push       = md_valid && md_ready && (md_a3 != 5'd0);
    // A slot is occupied when its distance past the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_hit
        logic [PW-1:0] w_dist;
        assign w_dist   = PW'(i) - r_rd_ptr;
        assign w_hit[i] = (CW'(w_dist) < r_count) && (r_fa3[i] == q_a);
    end
    assign q_pending = (q_a != 5'd0) && (|w_hit);
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fa3[r_wr_ptr] <= md_a3;
            r_fwd[r_wr_ptr] <= md_wd;
            r_fpc[r_wr_ptr] <= md_pc;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            RegWrite <= 1'b0;
            a3       <= '0;
            WD       <= '0;
            pc       <= '0;
        end else if (w_pipe_issue) begin
            RegWrite <= 1'b1;
            a3       <= pipe_a3;
            WD       <= pipe_wd;
            pc       <= pipe_pc;
        end else if (w_pop) begin
            RegWrite <= 1'b1;
            a3       <= r_fa3[r_rd_ptr];
            WD       <= r_fwd[r_rd_ptr];
            pc       <= r_fpc[r_rd_ptr];
        end else begin
            RegWrite <= 1'b0;
        end
    end
endmodule

// File: tb/tb_reg_wb_ctrl.sv
// tb_reg_wb_ctrl: vector table, directed multi-cycle sequences and random traffic
// checked against a queue-based model of the writeback arbiter.
module tb_reg_wb_ctrl;
    localparam int DEPTH = 4;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        reset, pipe_valid, md_valid, md_ready, q_pending, RegWrite;
    logic [4:0]  pipe_a3, md_a3, q_a, a3;
    logic [31:0] pipe_wd, pipe_pc, md_wd, md_pc, WD, pc;
    reg_wb_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_pc(pipe_pc),
        .md_valid(md_valid), .md_a3(md_a3), .md_wd(md_wd), .md_pc(md_pc), .md_ready(md_ready),
        .q_a(q_a), .q_pending(q_pending),
        .RegWrite(RegWrite), .a3(a3), .WD(WD), .pc(pc)
    );
    typedef struct packed {
        logic rst; logic pv; logic [4:0] pa3; logic [31:0] pwd; logic [31:0] ppc;
        logic mv; logic [4:0] ma3; logic [31:0] mwd; logic [31:0] mpc; logic [4:0] qa;
    } in_t;
    typedef struct packed {
        in_t i; logic rdy; logic pend; logic rw; logic [4:0] a3; logic [31:0] wd; logic [31:0] pc;
    } vec_t;
    typedef struct packed { logic [4:0] a3; logic [31:0] wd; logic [31:0] pc; } ent_t;
    int n_chk = 0;
    int n_pass = 0;
    ent_t mq[$];
    logic        m_rw = 1'b0;
    logic [4:0]  m_a3 = '0;
    logic [31:0] m_wd = '0, m_pc = '0;
    logic        act_rdy, act_pend, exp_rdy;
    logic [4:0]  wlog[$];
    vec_t        tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic in_t mk(input logic rst, input logic pv, input logic [4:0] pa3,
                               input logic [31:0] pwd, input logic [31:0] ppc, input logic mv,
                               input logic [4:0] ma3, input logic [31:0] mwd,
                               input logic [31:0] mpc, input logic [4:0] qa);
        in_t x;
        x.rst = rst; x.pv = pv; x.pa3 = pa3; x.pwd = pwd; x.ppc = ppc;
        x.mv = mv; x.ma3 = ma3; x.mwd = mwd; x.mpc = mpc; x.qa = qa;
        return x;
    endfunction

    function automatic vec_t mkv(input in_t i, input logic rdy, input logic pend, input logic rw,
                                 input logic [4:0] ea3, input logic [31:0] ewd, input logic [31:0] epc);
        vec_t v;
        v.i = i; v.rdy = rdy; v.pend = pend; v.rw = rw; v.a3 = ea3; v.wd = ewd; v.pc = epc;
        return v;
    endfunction

    // One clock: drive, check combinational outputs, advance model, check registered port.
    task automatic cyc(input in_t x);
        logic pend;
        ent_t e;
        reset = x.rst; pipe_valid = x.pv; pipe_a3 = x.pa3; pipe_wd = x.pwd; pipe_pc = x.ppc;
        md_valid = x.mv; md_a3 = x.ma3; md_wd = x.mwd; md_pc = x.mpc; q_a = x.qa;
        #1;
        exp_rdy = mq.size() < DEPTH;
        pend = 1'b0;
        foreach (mq[k]) if (x.qa != 0 && mq[k].a3 == x.qa) pend = 1'b1;
        act_rdy = md_ready;
        act_pend = q_pending;
        chk("md_ready", act_rdy, exp_rdy);
        chk("q_pending", act_pend, pend);
        if (x.rst) begin
            mq.delete(); m_rw = 0; m_a3 = 0; m_wd = 0; m_pc = 0;
        end else begin
            m_rw = 0;
            if (x.pv && x.pa3 != 0) begin
                m_rw = 1; m_a3 = x.pa3; m_wd = x.pwd; m_pc = x.ppc;
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_rw = 1; m_a3 = e.a3; m_wd = e.wd; m_pc = e.pc;
            end
            if (x.mv && exp_rdy && x.ma3 != 0) begin
                e.a3 = x.ma3; e.wd = x.mwd; e.pc = x.mpc;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("RegWrite", RegWrite, m_rw);
        chk("a3", a3, m_a3);
        chk("WD", WD, m_wd);
        chk("pc", pc, m_pc);
        if (RegWrite === 1'b1) wlog.push_back(a3);
    endtask

    task automatic do_reset();
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        wlog.delete();
    endtask

    task automatic idle(input int n, input logic [4:0] qa);
        for (int k = 0; k < n; k++) cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, qa));
    endtask

    initial begin
        int nxt;
        reset = 1; pipe_valid = 0; pipe_a3 = 0; pipe_wd = 0; pipe_pc = 0;
        md_valid = 0; md_a3 = 0; md_wd = 0; md_pc = 0; q_a = 0;
        @(posedge clk);
        #1;
        chk("rst_RegWrite", RegWrite, 0);
        chk("rst_a3", a3, 0);
        chk("rst_WD", WD, 0);
        chk("rst_pc", pc, 0);
        chk("rst_md_ready", md_ready, 1);
        chk("rst_q_pending", q_pending, 0);

        tbl[0] = mkv(mk(0, 1, 5, 32'h1234, 32'h3000, 0, 0, 0, 0, 0), 1, 0, 1, 5, 32'h1234, 32'h3000);
        tbl[1] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 5, 32'h1234, 32'h3000);
        tbl[2] = mkv(mk(0, 1, 3, 32'h33, 32'h200, 1, 7, 32'hAA, 32'h100, 7), 1, 0, 1, 3, 32'h33, 32'h200);
        tbl[3] = mkv(mk(0, 1, 0, 32'hDEAD, 32'h999, 0, 0, 0, 0, 7), 1, 1, 1, 7, 32'hAA, 32'h100);
        tbl[4] = mkv(mk(0, 0, 0, 0, 0, 1, 0, 32'h55, 32'h55, 0), 1, 0, 0, 7, 32'hAA, 32'h100);
        tbl[5] = mkv(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7), 1, 0, 0, 7, 32'hAA, 32'h100);
        tbl[6] = mkv(mk(0, 1, 0, 32'h77, 32'h77, 0, 0, 0, 0, 0), 1, 0, 0, 7, 32'hAA, 32'h100);
        tbl[7] = mkv(mk(1, 1, 9, 32'h99, 32'h99, 1, 4, 32'h44, 32'h44, 0), 1, 0, 0, 0, 0, 0);
        for (int r = 0; r < 8; r++) begin
            cyc(tbl[r].i);
            chk($sformatf("row%0d_rdy", r), act_rdy, tbl[r].rdy);
            chk($sformatf("row%0d_pend", r), act_pend, tbl[r].pend);
            chk($sformatf("row%0d_rw", r), RegWrite, tbl[r].rw);
            chk($sformatf("row%0d_a3", r), a3, tbl[r].a3);
            chk($sformatf("row%0d_wd", r), WD, tbl[r].wd);
            chk($sformatf("row%0d_pc", r), pc, tbl[r].pc);
        end

        // md results 8..11 with the pipeline idle
        do_reset();
        for (int k = 0; k < 7; k++) begin
            cyc(mk(0, 0, 0, 0, 0, k < 4, 5'(8 + k), 32'(k), 32'(k), 9));
            chk($sformatf("t2_pend%0d", k), act_pend, k == 2);
        end
        chk("t2_nwrites", wlog.size(), 4);
        foreach (wlog[j]) chk($sformatf("t2_order%0d", j), wlog[j], 8 + j);

        // fill under continuous pipeline traffic, then drain
        do_reset();
        for (int k = 0; k < 4; k++) cyc(mk(0, 1, 5'(1 + k), 0, 0, 1, 5'(12 + k), 32'(k), 32'(k), 0));
        cyc(mk(0, 1, 5, 0, 0, 1, 30, 0, 0, 14));
        chk("t3_full", act_rdy, 0);
        chk("t3_pend14", act_pend, 1);
        wlog.delete();
        idle(6, 0);
        chk("t3_nwrites", wlog.size(), 4);
        foreach (wlog[j]) chk($sformatf("t3_order%0d", j), wlog[j], 12 + j);

        // full FIFO, md_valid held high, pipeline idle
        do_reset();
        for (int k = 0; k < 4; k++) cyc(mk(0, 1, 5'(1 + k), 0, 0, 1, 5'(16 + k), 32'(k), 32'(k), 0));
        wlog.delete();
        nxt = 20;
        for (int k = 0; k < 8; k++) begin
            cyc(mk(0, 0, 0, 0, 0, 1, 5'(nxt), 32'(nxt), 32'(nxt), 0));
            if (k == 0) chk("t4_rdy_first_pop", act_rdy, 0);
            if (k == 1) chk("t4_rdy_after_pop", act_rdy, 1);
            if (exp_rdy) nxt++;
        end
        idle(10, 0);
        chk("t4_nwrites", wlog.size(), nxt - 16);
        foreach (wlog[j]) chk($sformatf("t4_order%0d", j), wlog[j], 16 + j);

        // reset with entries queued and a same-cycle pipeline request
        do_reset();
        for (int k = 0; k < 3; k++) cyc(mk(0, 1, 5'(1 + k), 0, 0, 1, 5'(20 + k), 32'(k), 32'(k), 0));
        cyc(mk(1, 1, 9, 32'h99, 32'h99, 1, 23, 0, 0, 20));
        chk("t6_rw", RegWrite, 0);
        chk("t6_a3", a3, 0);
        chk("t6_wd", WD, 0);
        chk("t6_pc", pc, 0);
        wlog.delete();
        for (int k = 0; k < 3; k++) begin
            cyc(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'(20 + k)));
            chk($sformatf("t6_rdy%0d", k), act_rdy, 1);
            chk($sformatf("t6_pend%0d", k), act_pend, 0);
        end
        idle(3, 0);
        chk("t6_no_stale", wlog.size(), 0);

        // random traffic against the model
        for (int k = 0; k < 3000; k++) begin
            cyc(mk($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 15)),
                   $urandom, $urandom, $urandom_range(0, 9) < 6, 5'($urandom_range(0, 15)),
                   $urandom, $urandom, 5'($urandom_range(0, 15))));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_wb_ctrl.md
REG_WB_CTRL -- requirements
Module: reg_wb_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of multi-cycle result FIFO entries (power of two, 2..8).
REQ-002 SHALL have port clk, input, 1, system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 SHALL have port pipe_valid, input, 1, pipeline writeback request this cycle; cannot be stalled.
REQ-005 SHALL have ports pipe_a3 (input, 5), pipe_wd (input, 32) and pipe_pc (input, 32): destination register, data and instruction PC of the pipeline request.
REQ-006 SHALL have port md_valid, input, 1, multi-cycle unit result offer.
REQ-007 SHALL have ports md_a3 (input, 5), md_wd (input, 32) and md_pc (input, 32): destination register, data and PC of the multi-cycle result.
REQ-008 SHALL have port md_ready, output, 1, FIFO can accept; transfer occurs when md_valid and md_ready are both high.
REQ-009 SHALL have ports q_a (input, 5) and q_pending (output, 1): combinational query; q_pending is high if any occupied FIFO entry targets q_a.
REQ-010 SHALL have ports RegWrite (output, 1), a3 (output, 5), WD (output, 32) and pc (output, 32): the registered register-file write port.

Function
REQ-011 SHALL issue at most one register-file write per cycle.
REQ-012 SHALL give pipe_valid absolute priority: the pipeline request is issued whenever pipe_valid=1 and pipe_a3!=0.
REQ-013 SHALL, when no pipeline request is issued, pop the FIFO head and issue it if the FIFO is non-empty.
REQ-014 SHALL register the issued request onto RegWrite/a3/WD/pc at the next rising edge (1-cycle latency); in cycles with no issue, RegWrite SHALL be 0 and a3/WD/pc SHALL hold their previous values.
REQ-015 SHALL drop any request with a3==0: a pipeline request with pipe_a3==0 issues nothing and lets the FIFO pop that cycle; an md transfer with md_a3==0 is accepted but not enqueued.
REQ-016 SHALL drive md_ready = (count < DEPTH), computed from registered count only, so it stays low when full even if a pop occurs the same cycle.
REQ-017 SHALL allow a simultaneous enqueue and pop; count is then unchanged.
REQ-018 SHALL keep FIFO order strictly first-in-first-out, with read and write pointers wrapping modulo DEPTH.
REQ-019 SHALL NOT reorder pipeline writes against queued md writes to the same register; the hazard unit is responsible for using q_pending to prevent this.
REQ-020 SHALL report an entry through q_pending until the cycle it is popped; an entry popped this cycle SHALL still count as pending in that cycle.
REQ-021 SHALL treat q_a==0 as never pending.
REQ-022 SHALL let the FIFO starve while pipe_valid is continuously asserted with a nonzero pipe_a3; no fairness is provided.

Reset
REQ-023 SHALL, on reset, clear count and both pointers, set RegWrite=0, a3=0, WD=0 and pc=0, and discard all queued entries.
REQ-024 SHALL give reset priority over all same-cycle requests, which are lost; md_ready SHALL be 1 in the first cycle after reset.
REQ-025 SHALL leave q_pending=0 for every q_a after reset.

Verification
REQ-026 SHALL pass test 1: pipe_valid=1, a3=5, wd=0x1234, pc=0x3000 -> next cycle RegWrite=1, a3=5, WD=0x1234, pc=0x3000.
REQ-027 SHALL pass test 2: 4 md transfers (a3=8..11) with pipe idle -> writes to 8,9,10,11 in order, each issued the cycle after the entry is enqueued; q_pending(q_a=9) stays 1 until 9 is issued.
REQ-028 SHALL pass test 3: fill the FIFO (DEPTH=4) while pipe_valid=1 every cycle -> md_ready=0 after the 4th transfer, no md writes issued; releasing pipe_valid drains 4 writes in order.
REQ-029 SHALL pass test 4: full FIFO, md_valid held high, pipe idle -> one pop per cycle, md_ready returns 1 one cycle after the first pop, and no entry is lost or duplicated.
REQ-030 SHALL pass test 5: pipe_a3=0 with pipe_valid=1 and a non-empty FIFO -> FIFO head issued that cycle; an md transfer with a3=0 -> accepted, count unchanged, no write issued.
REQ-031 SHALL pass test 6: reset asserted with 3 entries queued and pipe_valid=1 -> next cycle RegWrite=0, all outputs 0, md_ready=1, q_pending=0, and no stale write ever issued.
